// File: rtl/edge_monitor.sv
// Multi-channel edge monitor: per-channel synchroniser, optional debounce filter,
// qualified edge pulse, sticky flag and saturating event counter. Debounce is built only when EDGE_MONITOR_DEBOUNCE_EN is defined.
module edge_monitor #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 3,
    parameter int DEBOUNCE_W  = 8,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       signalIn,
    input  logic [2*CHANNELS-1:0]     edgeMode,
    input  logic [DEBOUNCE_W-1:0]     debounceLen,
    input  logic [CHANNELS-1:0]       clearSticky,
    input  logic                      countClear,
    output logic [CHANNELS-1:0]       levelOut,
    output logic [CHANNELS-1:0]       edgeFlag,
    output logic [CHANNELS-1:0]       edgeSticky,
    output logic [CHANNELS*CNT_W-1:0] eventCount
);

`ifndef EDGE_MONITOR_DEBOUNCE_EN
    // Without the filter the stability length has no consumer.
    logic w_unused_len;
    assign w_unused_len = ^debounceLen;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_level;
        logic                   r_level_prev;
        logic                   r_flag;
        logic                   r_sticky;
        logic [CNT_W-1:0]       r_count;
        logic                   w_sync_out;
        logic [1:0]             w_mode;
        logic                   w_rise;
        logic                   w_fall;
        logic                   w_hit;

        assign w_sync_out = r_sync[SYNC_STAGES-1];
        assign w_mode     = edgeMode[2*i +: 2];

        // NOTE: non-blocking assignments keep every stage sampling the pre-edge value of its neighbour.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], signalIn[i]};
            end
        end

`ifdef EDGE_MONITOR_DEBOUNCE_EN
        logic [DEBOUNCE_W-1:0] r_db_cnt;

        // The level moves only after debounceLen+1 consecutive mismatched cycles.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_db_cnt <= '0;
                r_level  <= 1'b0;
            end else if (w_sync_out != r_level) begin
                if (r_db_cnt == debounceLen) begin
                    r_level  <= w_sync_out;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
`else
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_level <= 1'b0;
            end else begin
                r_level <= w_sync_out;
            end
        end
`endif

        assign w_rise = r_level & ~r_level_prev;
        assign w_fall = ~r_level & r_level_prev;
        assign w_hit  = (w_rise & w_mode[0]) | (w_fall & w_mode[1]);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_level_prev <= 1'b0;
                r_flag       <= 1'b0;
                r_sticky     <= 1'b0;
                r_count      <= '0;
            end else begin
                r_level_prev <= r_level;
                r_flag       <= w_hit;
                r_sticky     <= w_hit | (r_sticky & ~clearSticky[i]);
                // A clear coinciding with an edge leaves that edge counted.
                if (countClear) begin
                    r_count <= {{(CNT_W-1){1'b0}}, w_hit};
                end else if (w_hit && (r_count != '1)) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end

        assign levelOut[i]                 = r_level;
        assign edgeFlag[i]                 = r_flag;
        assign edgeSticky[i]               = r_sticky;
        assign eventCount[CNT_W*i +: CNT_W] = r_count;
    end

endmodule

// File: tb/tb_edge_monitor.sv
// Bench for edge_monitor: directed scenarios plus random traffic, all checked
// cycle by cycle against a behavioural delay-line / run-length model.
module tb_edge_monitor;
    localparam int CH   = 4;
    localparam int SYNC = 3;
    localparam int DBW  = 8;
    localparam int CW   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [CH-1:0]     signalIn;
    logic [2*CH-1:0]   edgeMode;
    logic [DBW-1:0]    debounceLen;
    logic [CH-1:0]     clearSticky;
    logic              countClear;
    logic [CH-1:0]     levelOut;
    logic [CH-1:0]     edgeFlag;
    logic [CH-1:0]     edgeSticky;
    logic [CH*CW-1:0]  eventCount;

    always #5 clk = ~clk;

    edge_monitor #(.CHANNELS(CH), .SYNC_STAGES(SYNC), .DEBOUNCE_W(DBW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .signalIn(signalIn), .edgeMode(edgeMode),
        .debounceLen(debounceLen), .clearSticky(clearSticky), .countClear(countClear),
        .levelOut(levelOut), .edgeFlag(edgeFlag), .edgeSticky(edgeSticky), .eventCount(eventCount)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: input history queue, filtered level, mismatch run length, edge seen last cycle.
    logic [CH-1:0] m_hist[$];
    bit            m_level[CH];
    int            m_run[CH];
    bit            m_pend_r[CH];
    bit            m_pend_f[CH];
    bit            m_flag[CH];
    bit            m_sticky[CH];
    int            m_cnt[CH];

    function automatic int n_eff();
`ifdef EDGE_MONITOR_DEBOUNCE_EN
        return int'(debounceLen);
`else
        return 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        for (int k = 0; k < SYNC; k++) m_hist.push_back('0);
        for (int c = 0; c < CH; c++) begin
            m_level[c] = 0; m_run[c] = 0; m_pend_r[c] = 0; m_pend_f[c] = 0;
            m_flag[c] = 0; m_sticky[c] = 0; m_cnt[c] = 0;
        end
    endtask

    task automatic model_edge();
        logic [CH-1:0] s = m_hist[0];
        int            n = n_eff();
        for (int c = 0; c < CH; c++) begin
            logic [1:0] mode = edgeMode[2*c +: 2];
            bit f = (m_pend_r[c] && mode[0]) || (m_pend_f[c] && mode[1]);
            m_flag[c]   = f;
            m_sticky[c] = f || (m_sticky[c] && !clearSticky[c]);
            if (countClear) m_cnt[c] = f ? 1 : 0;
            else if (f && m_cnt[c] < (1 << CW) - 1) m_cnt[c]++;
            m_pend_r[c] = 0;
            m_pend_f[c] = 0;
            if (s[c] != m_level[c]) begin
                m_run[c]++;
                if (m_run[c] == n + 1) begin
                    m_pend_r[c] = s[c];
                    m_pend_f[c] = !s[c];
                    m_level[c]  = s[c];
                    m_run[c]    = 0;
                end
            end else begin
                m_run[c] = 0;
            end
        end
        m_hist.push_back(signalIn);
        void'(m_hist.pop_front());
    endtask

    task automatic check_all(input string tag);
        logic [CH-1:0]    el, ef, es;
        logic [CH*CW-1:0] ec;
        for (int c = 0; c < CH; c++) begin
            el[c] = m_level[c];
            ef[c] = m_flag[c];
            es[c] = m_sticky[c];
            ec[c*CW +: CW] = CW'(m_cnt[c]);
        end
        check({tag, ".level"}, 64'(levelOut), 64'(el));
        check({tag, ".flag"}, 64'(edgeFlag), 64'(ef));
        check({tag, ".sticky"}, 64'(edgeSticky), 64'(es));
        check({tag, ".count"}, 64'(eventCount), 64'(ec));
    endtask

    task automatic step(input string tag = "model");
        @(posedge clk);
        if (!reset) model_reset();
        else model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic steps(input int n, input string tag = "model");
        repeat (n) step(tag);
    endtask

    initial begin
        int fl[CH];
        int lat;
        logic seen;
        bit   settled;

        reset = 1'b0; signalIn = '0; edgeMode = '0; debounceLen = '0;
        clearSticky = '0; countClear = 1'b0;
        model_reset();
        steps(3, "reset");
        reset = 1'b1;

        // Single rising edge on ch0, latency SYNC + N + 2
        edgeMode = 8'b00_00_00_01;
        signalIn = 4'b0001;
        lat = SYNC + n_eff() + 2;
        for (int k = 1; k <= lat + 1; k++) begin
            step("lat0");
            check($sformatf("lat0_flag_e%0d", k), 64'(edgeFlag[0]), 64'(k == lat));
        end
        check("lat0_count", 64'(eventCount[CW-1:0]), 64'd1);
        check("lat0_sticky", 64'(edgeSticky[0]), 64'd1);

        // Debounce: short pulse rejected, long pulse accepted at SYNC + N + 2
        signalIn = '0;
        steps(8);
        debounceLen = 8'd4;
        edgeMode = 8'b00_00_11_01;
        countClear = 1'b1; step(); countClear = 1'b0;
        signalIn[1] = 1'b1; steps(4); signalIn[1] = 1'b0;
        steps(16);
        check("short_pulse_count", 64'(eventCount[2*CW-1:CW]), 64'((n_eff() >= 4) ? 0 : 2));
        countClear = 1'b1; step(); countClear = 1'b0;
        lat = SYNC + n_eff() + 2;
        for (int k = 1; k <= lat; k++) begin
            signalIn[1] = (k <= 5);
            step("long_pulse");
            check($sformatf("long_pulse_flag_e%0d", k), 64'(edgeFlag[1]), 64'(k == lat));
        end
        signalIn[1] = 1'b0;
        steps(16);
        check("long_pulse_count", 64'(eventCount[2*CW-1:CW]), 64'd2);

        // Per-channel modes with all channels toggling together
        debounceLen = '0;
        edgeMode = 8'b00_11_10_01;
        countClear = 1'b1; step(); countClear = 1'b0;
        for (int c = 0; c < CH; c++) fl[c] = 0;
        for (int k = 0; k < 16; k++) begin
            signalIn = (k < 8) ? 4'hF : 4'h0;
            step("modes");
            for (int c = 0; c < CH; c++) fl[c] += int'(edgeFlag[c]);
        end
        steps(6, "modes");
        check("modes_counts", 64'(eventCount), 64'({4'd0, 4'd2, 4'd1, 4'd1}));
        check("modes_flags_ch0", 64'(fl[0]), 64'd1);
        check("modes_flags_ch1", 64'(fl[1]), 64'd1);
        check("modes_flags_ch2", 64'(fl[2]), 64'd2 - 64'(edgeFlag[2] == 1'b0 ? 0 : 1));
        check("modes_flags_ch3", 64'(fl[3]), 64'd0);

        // Counter saturation, then clear coinciding with an edge
        edgeMode = 8'b00_00_00_01;
        for (int k = 0; k < 20; k++) begin
            signalIn[0] = 1'b1; steps(5);
            signalIn[0] = 1'b0; steps(5);
        end
        check("saturate", 64'(eventCount[CW-1:0]), 64'd15);
        signalIn[0] = 1'b1; steps(4);
        countClear = 1'b1; step("clr_edge"); countClear = 1'b0;
        check("clr_edge_flag", 64'(edgeFlag[0]), 64'd1);
        check("clr_edge_count", 64'(eventCount[CW-1:0]), 64'd1);
        signalIn[0] = 1'b0; steps(6);

        // Sticky clear coinciding with an edge: set wins
        edgeMode = 8'b00_11_00_00;
        signalIn[2] = 1'b1; steps(4);
        clearSticky = 4'b0100; step("stk_set");
        check("stk_set_wins", 64'(edgeSticky[2]), 64'd1);
        step("stk_clr");
        check("stk_clear_alone", 64'(edgeSticky[2]), 64'd0);
        clearSticky = '0;
        signalIn[2] = 1'b0; steps(6);

        // Reset mid-debounce: immediate clear, nothing after release
        debounceLen = 8'd10;
        edgeMode = 8'b11_11_11_11;
        signalIn[0] = 1'b1; steps(6);
        @(posedge clk);
        model_edge();
        #2 reset = 1'b0;
        signalIn = '0;
        model_reset();
        #1;
        check("async_rst_level", 64'(levelOut), 64'd0);
        check("async_rst_flag", 64'(edgeFlag), 64'd0);
        check("async_rst_sticky", 64'(edgeSticky), 64'd0);
        check("async_rst_count", 64'(eventCount), 64'd0);
        @(negedge clk);
        steps(2, "in_reset");
        reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step("post_rst");
            seen |= |edgeFlag;
        end
        check("post_rst_no_flag", 64'(seen), 64'd0);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            if (k % 50 == 0) edgeMode = 8'($urandom);
            settled = 1;
            for (int c = 0; c < CH; c++) if (m_run[c] != 0) settled = 0;
            if (settled && $urandom_range(0, 15) == 0) debounceLen = 8'($urandom_range(0, 3));
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 4) == 0) signalIn[c] = ~signalIn[c];
            for (int c = 0; c < CH; c++) clearSticky[c] = ($urandom_range(0, 7) == 0);
            countClear = ($urandom_range(0, 31) == 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/edge_monitor.md
EDGE_MONITOR -- requirements
Module: edge_monitor

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels, range 1..32.
REQ-002 Parameter SYNC_STAGES, default 3: synchroniser depth per channel, minimum 2.
REQ-003 Parameter DEBOUNCE_W, default 8: width of debounce length and per-channel debounce counter.
REQ-004 Parameter CNT_W, default 16: width of each per-channel event counter.
REQ-005 clk  input  1  single clock; all state SHALL be clocked on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 signalIn  input  CHANNELS  asynchronous inputs, bit i = channel i.
REQ-008 edgeMode  input  2*CHANNELS  per channel [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
REQ-009 debounceLen  input  DEBOUNCE_W  common stability length N in cycles; quasi-static.
REQ-010 clearSticky  input  CHANNELS  per-channel sticky clear, one-cycle or level.
REQ-011 countClear  input  1  clears all event counters.
REQ-012 levelOut  output  CHANNELS  filtered, synchronised level per channel.
REQ-013 edgeFlag  output  CHANNELS  one-cycle pulse per qualified edge.
REQ-014 edgeSticky  output  CHANNELS  latched edge indication per channel.
REQ-015 eventCount  output  CHANNELS*CNT_W  per-channel counters, channel i at [CNT_W*i +: CNT_W].

Function
REQ-016 Each channel SHALL pass signalIn[i] through a SYNC_STAGES flip-flop chain; the last stage is the synchronised value S.
REQ-017 Debounce: counter increments each cycle S != levelOut, resets to 0 when S == levelOut; when counter == N while mismatched, levelOut <= S and counter <= 0.
REQ-018 With N=0 levelOut SHALL follow S one cycle later; with N the change SHALL require N+1 consecutive mismatched cycles.
REQ-019 A mismatch shorter than N+1 cycles SHALL produce no levelOut change, no flag, no count.
REQ-020 Rising = levelOut 0->1, falling = 1->0, detected from levelOut and its previous-cycle copy.
REQ-021 edgeFlag[i] SHALL be registered, high exactly one cycle per edge matching edgeMode in that detection cycle; mode 00 suppresses flag, sticky and count, but levelOut still tracks.
REQ-022 Total latency: edgeFlag high SYNC_STAGES+N+2 rising edges after the first edge sampling the new input value.
REQ-023 edgeSticky[i] sets in the same cycle as edgeFlag[i]; clears on clearSticky[i]; simultaneous set and clear -> set wins.
REQ-024 eventCount[i] increments by 1 per edgeFlag[i], saturates at 2^CNT_W-1, no wrap.
REQ-025 countClear with simultaneous edgeFlag[i] -> eventCount[i] = 1; otherwise 0.
REQ-026 Channels SHALL be fully independent; simultaneous edges on all channels SHALL all be flagged and counted.
REQ-027 Changing debounceLen mid-filter SHALL take effect on the next compare; counter not reset.

Reset
REQ-028 While reset is low: sync chains, levelOut, previous-level copies, debounce counters, edgeFlag, edgeSticky and eventCount SHALL all be 0, asynchronously.
REQ-029 After reset release with signalIn[i] held high, channel i SHALL report one rising edge after the REQ-022 latency; this behaviour is intended.
REQ-030 Reset asserted mid-debounce or mid-pulse SHALL abort immediately with no residual flag.

Configuration
REQ-031 Macro EDGE_MONITOR_DEBOUNCE_EN defined: debounce counters and debounceLen per REQ-017..019 are implemented.
REQ-032 Macro undefined: no debounce counters; debounceLen is ignored; behaviour SHALL equal N=0 in all respects including latency SYNC_STAGES+2.

Verification
REQ-033 CHANNELS=4, SYNC_STAGES=3, N=0, mode ch0=01; ch0 0->1 -> edgeFlag[0] pulse 1 cycle at 5th edge, eventCount[0]=1, edgeSticky[0]=1.
REQ-034 N=4, ch1 mode 11; ch1 high 4 cycles then low -> no flag; high 5 cycles -> one rising flag at edge 3+4+2=9.
REQ-035 Modes 01/10/11/00 on ch0..3, all inputs toggle 0->1->0 -> flags: ch0 rise only, ch1 fall only, ch2 both, ch3 none; counts 1,1,2,0.
REQ-036 CNT_W=4, 20 rising edges on ch0 -> eventCount[0] holds 15; countClear coincident with edge -> 1.
REQ-037 clearSticky[2] coincident with ch2 edge -> edgeSticky[2] remains 1; next cycle clear alone -> 0.
REQ-038 Reset pulse low during a pending debounce on ch0 -> all outputs 0 within the reset, no flag after release while input low.
